// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode seven-segment driver with refresh prescaler,
// per-digit blanking/decimal points, leading-zero suppression and
// double-buffered (frame-boundary) loading.
module seg7_scan_display #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VW = 4 * NUM_DIGITS;

  logic [PW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  tick;
  logic                  last_digit;
  logic                  commit;

  logic [VW-1:0]         pend_value;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] pend_blank;
  logic                  pend_lz;
  logic                  pend_valid;

  logic [VW-1:0]         act_value;
  logic [NUM_DIGITS-1:0] act_dp;
  logic [NUM_DIGITS-1:0] act_blank;
  logic                  act_lz;

  logic [NUM_DIGITS-1:0] supp;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  // Hex glyph lookup, active-low gfedcba.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  assign tick       = (cnt == PW'(REFRESH_DIV - 1));
  assign last_digit = (idx == IW'(NUM_DIGITS - 1));
  assign commit     = tick && last_digit;

  // Refresh prescaler: one tick per digit slot.
  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + PW'(1);
  end

  // Scan index advances once per slot and wraps after the last digit.
  always_ff @(posedge clk) begin
    if (rst)       idx <= '0;
    else if (tick) idx <= last_digit ? '0 : idx + IW'(1);
  end

  // Pending/active double buffer; active only changes at a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_lz    <= 1'b0;
      pend_valid <= 1'b0;
      act_value  <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      act_lz     <= 1'b0;
    end else if (load && commit) begin
      act_value  <= value;
      act_dp     <= dp_in;
      act_blank  <= blank_in;
      act_lz     <= lz_en;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_value <= value;
      pend_dp    <= dp_in;
      pend_blank <= blank_in;
      pend_lz    <= lz_en;
      pend_valid <= 1'b1;
    end else if (commit && pend_valid) begin
      act_value  <= pend_value;
      act_dp     <= pend_dp;
      act_blank  <= pend_blank;
      act_lz     <= pend_lz;
      pend_valid <= 1'b0;
    end
  end

  // Leading-zero mask: walk down from the top digit; digit 0 always shows.
  always_comb begin
    logic run;
    supp = '0;
    run  = act_lz;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      if (run && (act_value[4*i +: 4] == 4'h0) && !act_dp[i]) supp[i] = 1'b1;
      else                                                   run     = 1'b0;
    end
  end

  // Next pin values for the currently selected digit.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if ((idx == IW'(i)) && !(act_blank[i] || supp[i])) begin
        an_nxt[i] = 1'b0;
        seg_nxt   = glyph(act_value[4*i +: 4]);
        dp_nxt    = ~act_dp[i];
      end
    end
  end

  // Registered pin outputs and frame boundary pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= commit;
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a driver applies directed and
// random stimulus and queues the pin values a time-based reference model
// predicts; a monitor pops and compares them after every clock edge.
module tb_seg7_scan_display;

  localparam int N   = 4;
  localparam int DIV = 4;
  localparam int FRAME = N * DIV;

  logic          clk = 1'b0;
  logic          rst;
  logic [4*N-1:0] value;
  logic          load;
  logic [N-1:0]  dp_in;
  logic [N-1:0]  blank_in;
  logic          lz_en;
  logic [N-1:0]  an;
  logic [6:0]    seg;
  logic          dp;
  logic          frame_done;

  seg7_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
    .blank_in(blank_in), .lz_en(lz_en), .an(an), .seg(seg), .dp(dp),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4*N-1:0] v;
    logic [N-1:0]   d;
    logic [N-1:0]   b;
    logic           lz;
  } disp_t;

  typedef struct {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         fd;
  } pins_t;

  pins_t exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  bit    stim_done = 1'b0;

  // Reference model: time since reset release decides the slot and frame.
  int    t;
  disp_t pend, act;
  bit    pv;
  logic [6:0] glyph_tab [16];

  initial begin
    glyph_tab[0]  = 7'b1000000; glyph_tab[1]  = 7'b1111001;
    glyph_tab[2]  = 7'b0100100; glyph_tab[3]  = 7'b0110000;
    glyph_tab[4]  = 7'b0011001; glyph_tab[5]  = 7'b0010010;
    glyph_tab[6]  = 7'b0000010; glyph_tab[7]  = 7'b1111000;
    glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0010000;
    glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b0000011;
    glyph_tab[12] = 7'b1000110; glyph_tab[13] = 7'b0100001;
    glyph_tab[14] = 7'b0000110; glyph_tab[15] = 7'b0001110;
  end

  function automatic pins_t show(input disp_t s, input int dig, input bit fd);
    pins_t p;
    bit    supp [N];
    bit    leading = s.lz;
    logic [3:0] nib;
    for (int i = N - 1; i >= 0; i--) begin
      nib = s.v[4*i +: 4];
      supp[i] = leading && (i != 0) && (nib == 4'h0) && !s.d[i];
      if (!supp[i]) leading = 1'b0;
    end
    p.an = '1; p.seg = 7'h7F; p.dp = 1'b1; p.fd = fd;
    if (!s.b[dig] && !supp[dig]) begin
      nib = s.v[4*dig +: 4];
      p.an[dig] = 1'b0;
      p.seg = glyph_tab[nib];
      p.dp  = ~s.d[dig];
    end
    return p;
  endfunction

  function automatic disp_t zero_disp();
    disp_t z;
    z.v = '0; z.d = '0; z.b = '0; z.lz = 1'b0;
    return z;
  endfunction

  // Drive one cycle of inputs and queue the pins expected after its edge.
  task automatic step(input logic r, input logic ld, input logic [4*N-1:0] v,
                      input logic [N-1:0] d, input logic [N-1:0] b, input logic lz);
    pins_t e;
    disp_t in_s;
    bit    commit;
    @(negedge clk);
    rst = r; load = ld; value = v; dp_in = d; blank_in = b; lz_en = lz;
    if (r) begin
      e.an = '1; e.seg = 7'h7F; e.dp = 1'b1; e.fd = 1'b0;
      t = 0; pend = zero_disp(); act = zero_disp(); pv = 1'b0;
    end else begin
      commit = ((t % FRAME) == FRAME - 1);
      e = show(act, (t / DIV) % N, commit);
      in_s.v = v; in_s.d = d; in_s.b = b; in_s.lz = lz;
      if (ld && commit) begin
        act = in_s; pv = 1'b0;
      end else if (ld) begin
        pend = in_s; pv = 1'b1;
      end else if (commit && pv) begin
        act = pend; pv = 1'b0;
      end
      t++;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, value, dp_in, blank_in, lz_en);
  endtask

  task automatic idle_until_commit();
    for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) idle(1);
  endtask

  // Monitor: compare every output cycle against the oldest expectation.
  initial begin
    pins_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
          n_fail++;
          $display("FAIL pins @%0t: got an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b",
                   $time, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_in = '0; lz_en = 1'b0;
    t = 0; pend = zero_disp(); act = zero_disp(); pv = 1'b0;

    // 1: reset then 1234 loaded at cycle 2, shown from the next frame
    step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 16'h1234, 4'b0000, 4'b0000, 1'b0);
    idle(2 * FRAME);

    // 2: leading-zero suppression, then value 0 with suppression
    step(1'b0, 1'b1, 16'h0070, 4'b0000, 4'b0000, 1'b1);
    idle(2 * FRAME);
    step(1'b0, 1'b1, 16'h0000, 4'b0000, 4'b0000, 1'b1);
    idle(2 * FRAME);

    // 3: two loads in one frame, last one wins
    idle(3);
    step(1'b0, 1'b1, 16'hAAAA, 4'b0000, 4'b0000, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 16'hBBBB, 4'b0000, 4'b0000, 1'b0);
    idle(2 * FRAME);

    // 4: load exactly on the commit cycle
    idle_until_commit();
    step(1'b0, 1'b1, 16'h5555, 4'b0000, 4'b0000, 1'b0);
    idle(2 * FRAME + 3);

    // 5: blanking and decimal point
    step(1'b0, 1'b1, 16'h8888, 4'b0001, 4'b0100, 1'b0);
    idle(2 * FRAME);

    // 6: reset during digit 2 with a pending load outstanding
    for (int i = 0; i < FRAME && ((t / DIV) % N) != 2; i++) idle(1);
    step(1'b0, 1'b1, 16'h9999, 4'b1111, 4'b0000, 1'b0);
    step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    idle(2 * FRAME);

    // Random traffic with leading zeros, blanking and occasional resets
    for (int i = 0; i < 2500; i++) begin
      logic [4*N-1:0] rv;
      int top;
      rv  = 16'($urandom);
      top = $urandom_range(0, N);
      for (int k = N - 1; k >= 0; k--) if (k >= N - top) rv[4*k +: 4] = 4'h0;
      if ($urandom_range(0, 299) == 0)
        step(1'b1, 1'b0, value, dp_in, blank_in, lz_en);
      else if ($urandom_range(0, 7) == 0)
        step(1'b0, 1'b1, rv,
             ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
             ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
             1'($urandom));
      else
        idle(1);
    end

    idle(2);
    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
